wb_master_bridge: RTL

Wishbone classic initiator that converts single-beat load/store requests from the core's memory port into Wishbone read/write cycles toward uncore slaves (GPIO, UART, timers), and returns read data or a bus error. Supports one outstanding transaction, with a valid/ready request channel and a valid/ready response channel. An optional watchdog terminates cycles to slaves that never acknowledge.

---
 rtl/wb_master_bridge_if.sv | 45 ++++
 rtl/wb_master_bridge.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wb_master_bridge_if.sv
// Request, response and Wishbone signal bundle for wb_master_bridge.
// The master modport is the bridge's view; slave is the core/bus-side view.
interface wb_master_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [3:0]        req_sel_i;
  logic              req_we_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [31:0]       wb_dat_o;
  logic [3:0]        wb_sel_o;
  logic              wb_we_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_sel_i, req_we_i,
    input  rsp_ready_i,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_sel_i, req_we_i,
    output rsp_ready_i,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator: one request in, one bus cycle, one response out.
// Define WB_MASTER_TIMEOUT_EN to build in the watchdog that ends unacknowledged cycles with an error.
module wb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_master_bridge_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_adr, w_adr_next;
  logic [31:0]       r_dat, w_dat_next;
  logic [3:0]        r_sel, w_sel_next;
  logic              r_we, w_we_next;
  logic [31:0]       r_rdata, w_rdata_next;
  logic              r_err, w_err_next;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_adr   <= w_adr_next;
      r_dat   <= w_dat_next;
      r_sel   <= w_sel_next;
      r_we    <= w_we_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt   <= w_cnt_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_adr_next   = r_adr;
    w_dat_next   = r_dat;
    w_sel_next   = r_sel;
    w_we_next    = r_we;
    w_rdata_next = r_rdata;
    w_err_next   = r_err;
`ifdef WB_MASTER_TIMEOUT_EN
    w_cnt_next   = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (bus.req_valid_i) begin
          w_adr_next   = bus.req_addr_i;
          w_dat_next   = bus.req_wdata_i;
          w_sel_next   = bus.req_sel_i;
          w_we_next    = bus.req_we_i;
          w_state_next = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          w_cnt_next   = '0;
`endif
        end
      end
      BUS: begin
        // err outranks ack; a real ack on the watchdog's last cycle still wins
        if (bus.wb_err_i) begin
          w_err_next   = 1'b1;
          w_rdata_next = '0;
          w_state_next = RESP;
        end else if (bus.wb_ack_i) begin
          w_err_next   = 1'b0;
          w_rdata_next = r_we ? 32'd0 : bus.wb_dat_i;
          w_state_next = RESP;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (w_timeout) begin
          w_err_next   = 1'b1;
          w_rdata_next = '0;
          w_state_next = RESP;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bus address/data lanes hold their last values between cycles; slaves qualify with stb.
  assign bus.req_ready_o = (r_state == IDLE);
  assign bus.rsp_valid_o = (r_state == RESP);
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;
  assign bus.wb_cyc_o    = (r_state == BUS);
  assign bus.wb_stb_o    = (r_state == BUS);
  assign bus.wb_adr_o    = r_adr;
  assign bus.wb_dat_o    = r_dat;
  assign bus.wb_sel_o    = r_sel;
  assign bus.wb_we_o     = r_we;

endmodule
